// File: rtl/debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_tx
// Description : Debug-unit TX framer. On a send request it snapshots
//               N_WORDS state words and streams HEADER, the data bytes
//               (word 0 first, LSB first) and an XOR checksum of the data
//               bytes to a UART transmitter via start/available/done.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_tx #(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         DATA_WIDTH_UART = 8,
    parameter int                         N_WORDS         = 2,
    parameter logic [DATA_WIDTH_UART-1:0] HEADER          = 8'hA5
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_send,
    input  logic [N_WORDS*DATA_WIDTH-1:0]   i_words,
    input  logic                            i_tx_available,
    input  logic                            i_tx_done,
    output logic                            o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0]      o_tx_byte,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int BPW     = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BC_W    = $clog2(BPW) + 1;
    localparam int WC_W    = $clog2(N_WORDS) + 1;
    localparam int FRAME_W = N_WORDS * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_AVAIL = 2'd1,
        WAIT_DONE  = 2'd2,
        FINISH     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_HEADER   = 2'd0,
        PH_DATA     = 2'd1,
        PH_CHECKSUM = 2'd2
    } phase_t;

    state_t                     state,      state_next;
    phase_t                     phase,      phase_next;
    // Snapshot is consumed by shifting right one byte per acknowledged data
    // byte, so the current data byte is always the low byte.
    logic [FRAME_W-1:0]         snap,       snap_next;
    logic [BC_W-1:0]            byte_cnt,   byte_cnt_next;
    logic [WC_W-1:0]            word_cnt,   word_cnt_next;
    logic [DATA_WIDTH_UART-1:0] checksum,   checksum_next;
    logic                       tx_signal_next;
    logic [DATA_WIDTH_UART-1:0] tx_byte_next;
    logic                       busy_next;
    logic                       done_next;
    logic [DATA_WIDTH_UART-1:0] cur_byte;

    // Select the byte belonging to the current phase of the frame
    always_comb begin
        cur_byte = HEADER;
        case (phase)
            PH_HEADER:   cur_byte = HEADER;
            PH_DATA:     cur_byte = snap[DATA_WIDTH_UART-1:0];
            PH_CHECKSUM: cur_byte = checksum;
            default:     cur_byte = HEADER;
        endcase
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_next     = state;
        phase_next     = phase;
        snap_next      = snap;
        byte_cnt_next  = byte_cnt;
        word_cnt_next  = word_cnt;
        checksum_next  = checksum;
        tx_signal_next = 1'b0;
        tx_byte_next   = o_tx_byte;
        busy_next      = o_busy;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (i_send) begin
                    snap_next     = i_words;
                    phase_next    = PH_HEADER;
                    byte_cnt_next = '0;
                    word_cnt_next = '0;
                    checksum_next = '0;
                    busy_next     = 1'b1;
                    state_next    = WAIT_AVAIL;
                end
            end

            WAIT_AVAIL: begin
                if (i_tx_available) begin
                    tx_byte_next   = cur_byte;
                    tx_signal_next = 1'b1;
                    state_next     = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                // A done coinciding with our own start pulse cannot refer to
                // the byte just launched, so it is discarded.
                if (i_tx_done && !o_tx_signal) begin
                    state_next = WAIT_AVAIL;
                    case (phase)
                        PH_HEADER: phase_next = PH_DATA;
                        PH_DATA: begin
                            checksum_next = checksum ^ o_tx_byte;
                            snap_next     = snap >> DATA_WIDTH_UART;
                            if (byte_cnt == BC_W'(BPW - 1)) begin
                                byte_cnt_next = '0;
                                if (word_cnt == WC_W'(N_WORDS - 1)) begin
                                    phase_next = PH_CHECKSUM;
                                end else begin
                                    word_cnt_next = word_cnt + 1'b1;
                                end
                            end else begin
                                byte_cnt_next = byte_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state_next = FINISH;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end
                    endcase
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state       <= IDLE;
            phase       <= PH_HEADER;
            snap        <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            checksum    <= '0;
            o_tx_signal <= 1'b0;
            o_tx_byte   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            snap        <= snap_next;
            byte_cnt    <= byte_cnt_next;
            word_cnt    <= word_cnt_next;
            checksum    <= checksum_next;
            o_tx_signal <= tx_signal_next;
            o_tx_byte   <= tx_byte_next;
            o_busy      <= busy_next;
            o_done      <= done_next;
        end
    end

endmodule
`default_nettype wire
